// File: rtl/c128_z80plus_pkg.sv
// Shared types and defaults for the C128 Z80 accelerator phase scheduler.
package c128_z80plus_pkg;

    typedef enum logic [1:0] {
        VIC  = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        SLOW = 2'd3
    } phase_state_e;

    localparam int HALF_PHASE_DOTS_DEF = 4;
    localparam int MIN_ACCESS_DOTS_DEF = 3;
    localparam int SYNC_STAGES_DEF     = 2;

    // Counter width for a half-phase of the given length, never narrower than one bit.
    function automatic int cnt_width(input int dots);
        return (dots > 2) ? $clog2(dots) : 1;
    endfunction

    localparam int PHASE_CNT_W = cnt_width(HALF_PHASE_DOTS_DEF);

endpackage

// File: rtl/z80p_sync.sv
// Multi-flop synchronizer for one asynchronous level, with a selectable reset value.
module z80p_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/z80_phase_scheduler.sv
// Dot-clock scheduler that gates a registered Z80 clock into the Z80 half-phase
// and stretches accesses with WAIT when they cannot finish before the VIC half-phase.
module z80_phase_scheduler
    import c128_z80plus_pkg::*;
#(
    parameter int HALF_PHASE_DOTS = HALF_PHASE_DOTS_DEF,
    parameter int MIN_ACCESS_DOTS = MIN_ACCESS_DOTS_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic CLKDOT,
    input  logic nRESET,
    input  logic CLK1MHZ,
    input  logic CLKZ80,
    input  logic nMREQ,
    input  logic nIORQ,
    input  logic nRFSH,
    input  logic CLOCKSEL,
    output logic CLKOUT,
    output logic WAIT,
    output logic ZPHASE
);

    localparam int               CNT_W   = cnt_width(HALF_PHASE_DOTS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PHASE_DOTS - 1);

    logic acc_raw;
    logic s1m, sz80, ssel, sacc;

    // Refresh cycles mask MREQ so they can never request a stretch.
    assign acc_raw = nRFSH & (~nMREQ | ~nIORQ);

    z80p_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_1m (
        .clk_i(CLKDOT), .rst_ni(nRESET), .d_i(CLK1MHZ), .q_o(s1m)
    );
    z80p_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_z80 (
        .clk_i(CLKDOT), .rst_ni(nRESET), .d_i(CLKZ80), .q_o(sz80)
    );
    z80p_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
        .clk_i(CLKDOT), .rst_ni(nRESET), .d_i(CLOCKSEL), .q_o(ssel)
    );
    z80p_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_acc (
        .clk_i(CLKDOT), .rst_ni(nRESET), .d_i(acc_raw), .q_o(sacc)
    );

    phase_state_e     state_q, state_d;
    logic             s1m_prev_q, acc_prev_q;
    logic             mode_fast_q, mode_fast_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic             clkout_q, clkout_d;
    logic             wait_q, wait_d;
    logic             zphase_q, zphase_d;
    logic             fall1m, rise1m, acc_start;
    logic             in_z80, short_window;

    assign fall1m       = s1m_prev_q & ~s1m;
    assign rise1m       = ~s1m_prev_q & s1m;
    assign acc_start    = sacc & ~acc_prev_q;
    assign in_z80       = (state_q == RUN) || (state_q == HOLD);
    assign short_window = (HALF_PHASE_DOTS - 1 - int'(phase_cnt_q)) < MIN_ACCESS_DOTS;

    always_ff @(posedge CLKDOT or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= VIC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            VIC: begin
                if (fall1m) state_d = mode_fast_q ? RUN : SLOW;
            end
            RUN: begin
                if (rise1m)                          state_d = VIC;
                else if (acc_start && short_window)  state_d = HOLD;
            end
            HOLD: begin
                // A falling phase edge here means the VIC phase was missed; restart as if from VIC.
                if (rise1m)      state_d = VIC;
                else if (fall1m) state_d = mode_fast_q ? RUN : SLOW;
            end
            SLOW: begin
                if (rise1m && ssel) state_d = VIC;
            end
            default: state_d = VIC;
        endcase
    end

    always_comb begin
        clkout_d = 1'b0;
        wait_d   = 1'b1;
        zphase_d = 1'b0;
        unique case (state_d)
            RUN, HOLD: begin
                zphase_d = 1'b1;
                wait_d   = (state_d != HOLD);
                // Fresh entry starts low so the first toggle is a clean 0->1 on the next dot.
                if (in_z80 && !fall1m) clkout_d = ~clkout_q;
            end
            SLOW:    clkout_d = sz80;
            default: clkout_d = 1'b0;
        endcase
    end

    always_comb begin
        phase_cnt_d = phase_cnt_q;
        if (fall1m) begin
            phase_cnt_d = '0;
        end else if (in_z80 && (phase_cnt_q != CNT_MAX)) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
        end
        mode_fast_d = rise1m ? ssel : mode_fast_q;
    end

    always_ff @(posedge CLKDOT or negedge nRESET) begin
        if (!nRESET) begin
            s1m_prev_q  <= 1'b1;
            acc_prev_q  <= 1'b0;
            mode_fast_q <= 1'b1;
            phase_cnt_q <= '0;
            clkout_q    <= 1'b0;
            wait_q      <= 1'b1;
            zphase_q    <= 1'b0;
        end else begin
            s1m_prev_q  <= s1m;
            acc_prev_q  <= sacc;
            mode_fast_q <= mode_fast_d;
            phase_cnt_q <= phase_cnt_d;
            clkout_q    <= clkout_d;
            wait_q      <= wait_d;
            zphase_q    <= zphase_d;
        end
    end

    assign CLKOUT = clkout_q;
    assign WAIT   = wait_q;
    assign ZPHASE = zphase_q;

endmodule
